multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-003 Inputs SHALL be:
- opcode  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
REQ-004 Memory outputs SHALL be:
- mem_read  out  1  read request
- mem_write  out  1  write request
- IorD  out  1  address select: 0=PC, 1=ALUOut
REQ-005 Write-enable outputs SHALL be:
- IRWrite  out  1  load instruction register
- PCWrite  out  1  PC write enable, with branch qualification already applied
- RegWrite  out  1  register-file write
- MemtoReg  out  1  write-back select: 0=ALUOut, 1=MDR
REQ-006 ALU and PC-select outputs SHALL be:
- ALUSrcA  out  2  00=PC, 01=reg A, 10=old PC
- ALUSrcB  out  2  00=reg B, 01=constant 4, 10=immediate
- ALUOp  out  2  00=add, 01=sub/branch, 10=R-type funct decode
- PCSource  out  1  0=ALU result, 1=ALUOut
REQ-007 Status outputs SHALL be:
- illegal  out  1  unsupported instruction trapped
- state  out  4  current state, for debug
- instret  out  CNT_W  retired-instruction count

Function
REQ-008 The state encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, TRAP=9.
REQ-009 Supported opcodes SHALL be R-type 0110011, load 0000011, store 0100011 and beq 1100011 (beq requires funct3=000); every other opcode or funct3 SHALL be illegal.
REQ-010 FETCH SHALL assert mem_read, with IorD=0, ALUSrcA=00, ALUSrcB=01 and ALUOp=00; IRWrite and PCWrite (PCSource=0) SHALL assert only in the cycle mem_ready=1; FETCH->DECODE on mem_ready, else the state holds.
REQ-011 DECODE SHALL drive ALUSrcA=10, ALUSrcB=10 and ALUOp=00 to compute the branch target; it then moves to MEMADR for load/store, EXEC for R-type, BRANCH for beq, else TRAP.
REQ-012 MEMADR SHALL drive ALUSrcA=01, ALUSrcB=10 and ALUOp=00; it moves to MEMRD for load and MEMWR for store.
REQ-013 MEMRD SHALL assert mem_read with IorD=1; it moves to MEMWB on mem_ready, else holds.
REQ-014 MEMWB SHALL assert RegWrite with MemtoReg=1, then move to FETCH.
REQ-015 MEMWR SHALL assert mem_write with IorD=1; it moves to FETCH on mem_ready, else holds.
REQ-016 EXEC SHALL drive ALUSrcA=01, ALUSrcB=00 and ALUOp=10, then move to RWB.
REQ-017 RWB SHALL assert RegWrite with MemtoReg=0, then move to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=01, ALUSrcB=00, ALUOp=01 and PCSource=1, with PCWrite=zero; it then moves to FETCH.
REQ-019 TRAP SHALL assert illegal, hold all write enables and requests at 0, and be left only by rst.
REQ-020 Any output not listed for a state SHALL be 0; no write enable or memory request SHALL ever be X.
REQ-021 mem_ready SHALL be ignored in states with no request outstanding.
REQ-022 mem_read and mem_write SHALL stay asserted, with stable IorD, until the cycle mem_ready=1 is sampled; this holds for an arbitrary number of wait cycles.
REQ-023 instret SHALL increment by 1 on the clock edge leaving MEMWB, RWB or BRANCH, or leaving MEMWR with mem_ready=1; it SHALL wrap from 2^CNT_W-1 to 0 and SHALL never increment in TRAP.
REQ-024 With zero-wait memory, latency SHALL be: R-type 4 cycles, load 5, store 4, beq 3.

Reset
REQ-025 rst sampled high SHALL set state=FETCH, instret=0 and illegal=0; the outputs SHALL then be the FETCH values (mem_read=1).
REQ-026 rst SHALL override every transition, including mid-wait in MEMRD/MEMWR and in TRAP; the aborted access SHALL not retire, and mem_read SHALL be re-asserted in FETCH the cycle after reset.

Verification
REQ-027 R-type add, mem_ready always 1: states 0,1,6,7,0; RegWrite=1 only in state 7; instret 0->1.
REQ-028 Load with mem_ready=0 for 3 cycles in MEMRD: mem_read and IorD=1 held 4 cycles; MEMWB RegWrite=1 with MemtoReg=1; total 8 cycles.
REQ-029 beq with zero=1, then beq with zero=0: PCWrite=1 with PCSource=1 in BRANCH only for the first; instret increments both times.
REQ-030 Opcode 0010011 in DECODE: state 9 next cycle; illegal=1 held for 10 cycles; instret unchanged; rst -> state 0, illegal 0.
REQ-031 instret preloaded near all-ones (CNT_W=4, 15 retirements) plus 1 store: instret wraps 15->0 on the edge leaving MEMWR.
REQ-032 rst asserted during MEMWR wait: next state 0, mem_write=0, instret not incremented.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32-subset datapath (R-type, lw, sw, beq).
// Decodes state into datapath controls and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q;
  logic             retire_s;
  logic             is_r_s, is_load_s, is_store_s, is_beq_s;

  assign is_r_s     = (opcode == OP_R);
  assign is_load_s  = (opcode == OP_LOAD);
  assign is_store_s = (opcode == OP_STORE);
  assign is_beq_s   = (opcode == OP_BEQ) && (funct3 == 3'b000);

  // Next-state selection and retirement detection
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        if (is_load_s || is_store_s) state_d = S_MEMADR;
        else if (is_r_s)             state_d = S_EXEC;
        else if (is_beq_s)           state_d = S_BRANCH;
        else                         state_d = S_TRAP;
      end
      S_MEMADR: begin
        if (is_load_s)       state_d = S_MEMRD;
        else if (is_store_s) state_d = S_MEMWR;
        else                 state_d = S_TRAP;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_BRANCH: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      // Unreachable encodings are treated as a trap rather than silently recovering
      default:  state_d = S_TRAP;
    endcase
  end

  // Counter wraps naturally at 2^CNT_W
  always_comb begin
    if (retire_s) instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          instret_d = instret_q;
  end

  // State, retirement counter and trap flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= (state_d == S_TRAP);
    end
  end

  // Datapath control decode; FETCH/BRANCH enables are qualified by same-cycle inputs
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSource  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
      end
      S_RWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 2'b01;
        ALUOp    = 2'b01;
        PCSource = 1'b1;
        PCWrite  = zero;
      end
      S_TRAP:   mem_read = 1'b0;
      default:  mem_read = 1'b0;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule
